// File: rtl/tlv320_i2s_pkg.sv
// Shared constants and types for the TLV320 I2S master: slot geometry and the
// stereo sample pair carried through the transmit holding register.
package tlv320_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int DATA_START = 1;
    localparam int DATA_END   = 16;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } pair_t;

    // Slot positions that carry sample bits; position 0 is the I2S one-bit delay.
    function automatic logic in_data_slot(input logic [4:0] s);
        return (s >= 5'(DATA_START)) && (s <= 5'(DATA_END));
    endfunction
endpackage

// File: rtl/tlv320_i2s_if.sv
// Codec serial pins plus the transmit/receive sample handshakes of the I2S master.
interface tlv320_i2s_if;
    import tlv320_pkg::*;

    logic                bclk;
    logic                lrclk;
    logic                dacdat;
    logic                adcdat;
    logic [SAMPLE_W-1:0] tx_left;
    logic [SAMPLE_W-1:0] tx_right;
    logic                tx_valid;
    logic                tx_ready;
    logic [SAMPLE_W-1:0] rx_left;
    logic [SAMPLE_W-1:0] rx_right;
    logic                rx_valid;
    logic                tx_underrun;

    modport master (
        output bclk, lrclk, dacdat, tx_ready, rx_left, rx_right, rx_valid, tx_underrun,
        input  adcdat, tx_left, tx_right, tx_valid
    );

    modport slave (
        input  bclk, lrclk, dacdat, tx_ready, rx_left, rx_right, rx_valid, tx_underrun,
        output adcdat, tx_left, tx_right, tx_valid
    );
endinterface

// File: rtl/tlv320_i2s_clkgen.sv
// BCLK divider and 64-bit frame counter; rise/fall strobe the inclk cycle whose
// closing edge moves bclk high/low.
module i2s_clkgen
    import tlv320_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic                          inclk_i,
    input  logic                          reset_n_i,
    output logic                          bclk_o,
    output logic                          lrclk_o,
    output logic                          rise_o,
    output logic                          fall_o,
    output logic [$clog2(FRAME_BITS)-1:0] bit_cnt_o
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [DW-1:0] RISE_CNT = DW'(BCLK_DIV / 2 - 1);
    localparam logic [DW-1:0] FALL_CNT = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] HALF_CNT = DW'(BCLK_DIV / 2);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q;
    logic          bclk_q;

    assign rise_o    = (div_cnt_q == RISE_CNT);
    assign fall_o    = (div_cnt_q == FALL_CNT);
    assign div_cnt_d = fall_o ? '0 : div_cnt_q + DW'(1);

    // bclk is decoded from the next count so it stays in phase with div_cnt_q.
    always_ff @(posedge inclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= (div_cnt_d >= HALF_CNT);
            if (fall_o) bit_cnt_q <= bit_cnt_q + BW'(1);
        end
    end

    assign bclk_o    = bclk_q;
    assign lrclk_o   = bit_cnt_q[BW-1];
    assign bit_cnt_o = bit_cnt_q;
endmodule

// File: rtl/tlv320_i2s.sv
// I2S master for the TLV320: drives BCLK/LRCLK, serialises a held DAC pair once
// per frame and deserialises the ADC pair, MSB first with the one-bit delay.
module tlv320_i2s
    import tlv320_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic         inclk,
    input  logic         reset_n,
    tlv320_i2s_if.master bus
);
    localparam int BW = $clog2(FRAME_BITS);
    localparam int SW = $clog2(SLOT_BITS);
    localparam int PW = 2 * SAMPLE_W;

    logic                rise, fall;
    logic [BW-1:0]       bit_cnt;
    logic [SW-1:0]       slot, slot_next;
    logic                frame_load, accept;

    pair_t               hold_q;
    logic                hold_full_q;
    logic [PW-1:0]       tx_sr_q;
    logic                dacdat_q, tx_underrun_q;
    logic [SAMPLE_W-1:0] rx_sr_q, rx_sr_d, rx_left_lat_q, rx_left_q, rx_right_q;
    logic                rx_valid_q;

    i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
        .inclk_i   (inclk),
        .reset_n_i (reset_n),
        .bclk_o    (bus.bclk),
        .lrclk_o   (bus.lrclk),
        .rise_o    (rise),
        .fall_o    (fall),
        .bit_cnt_o (bit_cnt)
    );

    assign slot       = bit_cnt[SW-1:0];
    assign slot_next  = slot + SW'(1);
    assign frame_load = fall && (bit_cnt == BW'(FRAME_BITS - 1));
    assign accept     = bus.tx_valid && !hold_full_q;
    assign rx_sr_d    = {rx_sr_q[SAMPLE_W-2:0], bus.adcdat};

    // Accept and a full-register load are exclusive, so one block owns hold_full_q.
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            tx_sr_q       <= '0;
            dacdat_q      <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            tx_underrun_q <= 1'b0;
            if (accept) begin
                hold_q      <= pair_t'({bus.tx_left, bus.tx_right});
                hold_full_q <= 1'b1;
            end
            if (frame_load) begin
                dacdat_q <= 1'b0;
                if (hold_full_q) begin
                    tx_sr_q     <= hold_q;
                    hold_full_q <= 1'b0;
                end else begin
                    tx_sr_q       <= '0;
                    tx_underrun_q <= 1'b1;
                end
            end else if (fall) begin
                // Left then right bits drain from the top as each slot's data window opens.
                if (in_data_slot(slot_next)) begin
                    dacdat_q <= tx_sr_q[PW-1];
                    tx_sr_q  <= {tx_sr_q[PW-2:0], 1'b0};
                end else begin
                    dacdat_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sr_q       <= '0;
            rx_left_lat_q <= '0;
            rx_left_q     <= '0;
            rx_right_q    <= '0;
            rx_valid_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (rise) begin
                if (in_data_slot(slot)) rx_sr_q <= rx_sr_d;
                if (bit_cnt == BW'(DATA_END)) rx_left_lat_q <= rx_sr_d;
                if (bit_cnt == BW'(SLOT_BITS + DATA_END)) begin
                    rx_left_q  <= rx_left_lat_q;
                    rx_right_q <= rx_sr_d;
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.dacdat      = dacdat_q;
    assign bus.tx_ready    = !hold_full_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.rx_left     = rx_left_q;
    assign bus.rx_right    = rx_right_q;
    assign bus.rx_valid    = rx_valid_q;
endmodule

// File: tb/tb_tlv320_i2s.sv
// Randomized scoreboard bench for tlv320_i2s: frame-level model of what each
// frame must carry, checked by a monitor that follows the inclk cycle count.
module tb_tlv320_i2s;
    localparam int DIV   = 4;
    localparam int FRAME = 64 * DIV;
    localparam int NF    = 10;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        und;
    } txe_t;

    logic inclk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc;
    int   passed = 0;
    int   total = 0;

    txe_t        txq[$];
    logic [31:0] rxq[$];
    logic [63:0] fbits;
    bit          rx_seen;

    tlv320_i2s_if bus();

    tlv320_i2s #(.BCLK_DIV(DIV)) dut (
        .inclk   (inclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 inclk = ~inclk;

    // Number of inclk rising edges since reset release = DUT state index.
    always @(posedge inclk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    endtask

    task automatic chk_fail(input string nm);
        total++;
        $display("FAIL %s: got event expected none (cyc %0d)", nm, cyc);
    endtask

    task automatic wait_cyc(input int n);
        int b = 0;
        while (cyc != n && b < 20000) begin
            @(negedge inclk);
            b++;
        end
        if (cyc != n) begin
            $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, n);
            $fatal(1);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_bclk"},     64'(bus.bclk), 64'd0);
        chk({nm, "_lrclk"},    64'(bus.lrclk), 64'd0);
        chk({nm, "_dacdat"},   64'(bus.dacdat), 64'd0);
        chk({nm, "_tx_ready"}, 64'(bus.tx_ready), 64'd1);
        chk({nm, "_rx_left"},  64'(bus.rx_left), 64'd0);
        chk({nm, "_rx_right"}, 64'(bus.rx_right), 64'd0);
        chk({nm, "_rx_valid"}, 64'(bus.rx_valid), 64'd0);
        chk({nm, "_underrun"}, 64'(bus.tx_underrun), 64'd0);
    endtask

    function automatic txe_t mk(input logic [15:0] l, input logic [15:0] r, input logic u);
        txe_t e;
        e.l = l; e.r = r; e.und = u;
        return e;
    endfunction

    // Codec model: fresh random words each frame, MSB one bit after the slot edge,
    // junk outside the data window.
    initial begin
        logic [15:0] rl, rr, w;
        int b, s;
        bus.adcdat = 1'b0;
        rl = '0; rr = '0;
        forever begin
            @(negedge inclk);
            if (reset_n) begin
                if (cyc % FRAME == 0) begin
                    rl = 16'($urandom);
                    rr = 16'($urandom);
                    rxq.push_back({rl, rr});
                end
                if (cyc % DIV == 0) begin
                    b = (cyc / DIV) % 64;
                    s = b % 32;
                    w = (b < 32) ? rl : rr;
                    bus.adcdat = (s >= 1 && s <= 16) ? w[16 - s] : 1'($urandom);
                end
            end
        end
    end

    // Monitor: clocks, underrun pulse, per-frame dacdat image and rx words.
    initial begin
        int ph, b;
        txe_t e;
        logic [31:0] rw;
        forever begin
            @(negedge inclk);
            if (reset_n) begin
                ph = cyc % FRAME;
                b  = ph / DIV;
                chk("bclk",  64'(bus.bclk),  64'((cyc % DIV) >= DIV / 2));
                chk("lrclk", 64'(bus.lrclk), 64'(b >= 32));
                if (ph == 0) begin
                    rx_seen = 1'b0;
                    if (txq.size() == 0) chk_fail("txq_empty");
                    else chk("tx_underrun", 64'(bus.tx_underrun), 64'(txq[0].und));
                end else begin
                    chk("tx_underrun_idle", 64'(bus.tx_underrun), 64'd0);
                end
                if (cyc % DIV == DIV / 2) fbits[63 - b] = bus.dacdat;
                if (ph == FRAME - 1) begin
                    if (txq.size() == 0) chk_fail("txq_empty_end");
                    else begin
                        e = txq.pop_front();
                        chk("dacdat_frame", fbits, {1'b0, e.l, 15'd0, 1'b0, e.r, 15'd0});
                    end
                end
                if (bus.rx_valid) begin
                    rx_seen = 1'b1;
                    chk("rx_valid_time", 64'(ph), 64'(48 * DIV + DIV / 2));
                    if (rxq.size() == 0) chk_fail("rx_unexpected");
                    else begin
                        rw = rxq.pop_front();
                        chk("rx_left",  64'(bus.rx_left),  64'(rw[31:16]));
                        chk("rx_right", 64'(bus.rx_right), 64'(rw[15:0]));
                    end
                end
                if (ph == 250) chk("rx_valid_seen", 64'(rx_seen), 64'd1);
            end
        end
    end

    initial begin
        int k, mode, off;
        logic [15:0] pl, pr;
        logic exp_rdy;
        bus.tx_valid = 1'b0;
        bus.tx_left  = '0;
        bus.tx_right = '0;
        repeat (3) @(posedge inclk);
        #1 check_reset_vals("reset");
        txq.push_back(mk(16'h0, 16'h0, 1'b0));
        @(posedge inclk);
        #1 reset_n = 1'b1;

        k = 0;
        exp_rdy = 1'b1;
        while (k < NF) begin
            wait_cyc(FRAME * k + 1);
            chk("ready_frame_start", 64'(bus.tx_ready), 64'(exp_rdy));
            mode = $urandom_range(0, 2);
            if (k == 0) mode = 1;
            if (k == 3) mode = 2;
            if (k == 6) mode = 0;
            if (mode == 0) begin
                txq.push_back(mk(16'h0, 16'h0, 1'b1));
                exp_rdy = 1'b1;
                k += 1;
            end else if (mode == 1) begin
                off = $urandom_range(4, 250);
                pl = (k == 0) ? 16'hA5C3 : 16'($urandom);
                pr = (k == 0) ? 16'h8001 : 16'($urandom);
                wait_cyc(FRAME * k + off);
                bus.tx_left = pl; bus.tx_right = pr; bus.tx_valid = 1'b1;
                txq.push_back(mk(pl, pr, 1'b0));
                chk("ready_idle", 64'(bus.tx_ready), 64'd1);
                wait_cyc(FRAME * k + off + 1);
                bus.tx_valid = 1'b0;
                bus.tx_left = 16'($urandom);
                chk("ready_full", 64'(bus.tx_ready), 64'd0);
                exp_rdy = 1'b1;
                k += 1;
            end else begin
                // Offer lands in the load cycle: this frame underruns, pair goes next.
                pl = 16'($urandom); pr = 16'($urandom);
                wait_cyc(FRAME * k + FRAME - 1);
                bus.tx_left = pl; bus.tx_right = pr; bus.tx_valid = 1'b1;
                txq.push_back(mk(16'h0, 16'h0, 1'b1));
                txq.push_back(mk(pl, pr, 1'b0));
                chk("ready_loadcyc", 64'(bus.tx_ready), 64'd1);
                wait_cyc(FRAME * (k + 1));
                bus.tx_valid = 1'b0;
                chk("ready_captured", 64'(bus.tx_ready), 64'd0);
                off = $urandom_range(4, 240);
                wait_cyc(FRAME * (k + 1) + off);
                bus.tx_left = ~pl; bus.tx_right = ~pr; bus.tx_valid = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    chk("ready_full_reject", 64'(bus.tx_ready), 64'd0);
                    wait_cyc(FRAME * (k + 1) + off + i + 1);
                end
                bus.tx_valid = 1'b0;
                exp_rdy = 1'b1;
                k += 2;
            end
        end

        // Mid-frame reset with a pair held: everything clears and the pair is dropped.
        wait_cyc(FRAME * k + 100);
        bus.tx_left = 16'hBEEF; bus.tx_right = 16'h1357; bus.tx_valid = 1'b1;
        chk("ready_pre_reset", 64'(bus.tx_ready), 64'd1);
        wait_cyc(FRAME * k + 101);
        bus.tx_valid = 1'b0;
        chk("ready_held", 64'(bus.tx_ready), 64'd0);
        wait_cyc(FRAME * k + 40 * DIV + 2);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("mid_reset");
        txq.delete();
        rxq.delete();
        txq.push_back(mk(16'h0, 16'h0, 1'b0));
        txq.push_back(mk(16'h0, 16'h0, 1'b1));
        txq.push_back(mk(16'h0, 16'h0, 1'b1));
        repeat (3) @(posedge inclk);
        #1 check_reset_vals("reset_hold");
        reset_n = 1'b1;
        wait_cyc(1);
        chk("ready_after_reset", 64'(bus.tx_ready), 64'd1);
        wait_cyc(3 * FRAME - 1);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
